// File: rtl/riscy_pkg.sv
// riscy_pkg: shared decode constants, funct3 encoding and small helpers for the
// decode/operand-fetch stage.
package riscy_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] FUNCT7_ALT = 7'h20;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    // Sign-extend a 12-bit I-type immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

    // Zero-extend a 5-bit shift amount to the datapath width.
    function automatic logic [XLEN-1:0] zext5(input logic [4:0] shamt);
        return {{(XLEN-5){1'b0}}, shamt};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: instruction-in, operands-out and writeback signals of the decode stage.
// slave = the decode stage itself, master = its environment (fetch, ALU, writeback).
interface id_stage_if;
    import riscy_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [4:0]      ex_rd;
    logic            ex_illegal;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
        output in_ready, ex_valid, ex_rs1, ex_rs2, ex_funct3, ex_funct7, ex_rd, ex_illegal
    );

    modport master (
        output in_valid, in_instr, ex_ready, wb_en, wb_addr, wb_data,
        input  in_ready, ex_valid, ex_rs1, ex_rs2, ex_funct3, ex_funct7, ex_rd, ex_illegal
    );

endinterface

// File: rtl/id_stage_regfile.sv
// id_stage_regfile: 32x32 architectural register file, two combinational read
// ports, one posedge write port, x0 reads as zero and ignores writes.
module id_stage_regfile
    import riscy_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_mem [NREGS];

    // Register array write; x0 is never stored to so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= {XLEN{1'b0}};
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? {XLEN{1'b0}} : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? {XLEN{1'b0}} : r_mem[i_raddr2];

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I OP/OP-IMM decode and operand fetch with a busy-bit scoreboard.
// Optional feature macro: ID_BYPASS_EN -- forward a same-cycle writeback into the
// operands and drop the matching source hazard.
module id_stage
    import riscy_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    id_stage_if.slave io_bus
);

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_is_op;
    logic            w_is_imm;
    logic            w_legal;
    logic            w_shift_imm;

    // Operand sources
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;
    logic            w_byp1;
    logic            w_byp2;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;

    // Handshake and scoreboard
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_accept;
    logic [31:0]     r_busy;
    logic [31:0]     w_clr_mask;
    logic [31:0]     w_set_mask;
    logic [31:0]     w_busy_nx;

    // Next values for the ALU-facing register
    logic [XLEN-1:0] w_nx_rs2;
    logic [6:0]      w_nx_funct7;
    logic [4:0]      w_nx_rd;
    logic            w_nx_illegal;

    // ALU-facing pipeline register
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_rs1;
    logic [XLEN-1:0] r_ex_rs2;
    logic [2:0]      r_ex_funct3;
    logic [6:0]      r_ex_funct7;
    logic [4:0]      r_ex_rd;
    logic            r_ex_illegal;

    assign w_opcode    = io_bus.in_instr[6:0];
    assign w_rd        = io_bus.in_instr[11:7];
    assign w_funct3    = io_bus.in_instr[14:12];
    assign w_rs1       = io_bus.in_instr[19:15];
    assign w_rs2       = io_bus.in_instr[24:20];
    assign w_is_op     = (w_opcode == OPC_OP);
    assign w_is_imm    = (w_opcode == OPC_OP_IMM);
    assign w_legal     = w_is_op | w_is_imm;
    assign w_shift_imm = (w_funct3 == F3_SLL) || (w_funct3 == F3_SR);

    id_stage_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rf_rd1),
        .o_rdata2 (w_rf_rd2),
        .i_we     (io_bus.wb_en),
        .i_waddr  (io_bus.wb_addr),
        .i_wdata  (io_bus.wb_data)
    );

`ifdef ID_BYPASS_EN
    // A writeback landing this cycle feeds the operand directly.
    assign w_byp1 = io_bus.wb_en && (io_bus.wb_addr == w_rs1) && (w_rs1 != 5'd0);
    assign w_byp2 = io_bus.wb_en && (io_bus.wb_addr == w_rs2) && (w_rs2 != 5'd0);
`else
    // Without forwarding, operands only ever come from stored register state.
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_src1 = w_byp1 ? io_bus.wb_data : w_rf_rd1;
    assign w_src2 = w_byp2 ? io_bus.wb_data : w_rf_rd2;

    // Scoreboard hazard: RAW on rs1 (and rs2 for OP), WAW on rd; illegal ops never stall
    always_comb begin
        w_hazard = 1'b0;
        if (w_legal) begin
            w_hazard = (r_busy[w_rs1] & ~w_byp1)
                     | (w_is_op & r_busy[w_rs2] & ~w_byp2)
                     | r_busy[w_rd];
        end else begin
            w_hazard = 1'b0;
        end
    end

    assign w_in_ready      = (~r_ex_valid | io_bus.ex_ready) & ~w_hazard;
    assign w_accept        = io_bus.in_valid & w_in_ready;
    assign io_bus.in_ready = w_in_ready;

    // Decode operand B, funct7 and destination for the offered instruction
    always_comb begin
        w_nx_rs2     = w_src2;
        w_nx_funct7  = 7'h00;
        w_nx_rd      = w_rd;
        w_nx_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_nx_rs2    = w_src2;
                w_nx_funct7 = io_bus.in_instr[31:25];
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry only the shamt as operand B; their upper
                // immediate bits travel as funct7 (SRLI vs SRAI). Other immediate
                // ops keep funct7 at zero so ADDI can never look like SUB.
                if (w_shift_imm) begin
                    w_nx_rs2    = zext5(io_bus.in_instr[24:20]);
                    w_nx_funct7 = io_bus.in_instr[31:25];
                end else begin
                    w_nx_rs2    = sext12(io_bus.in_instr[31:20]);
                    w_nx_funct7 = 7'h00;
                end
            end
            default: begin
                w_nx_rs2     = w_src2;
                w_nx_funct7  = 7'h00;
                w_nx_rd      = 5'd0;
                w_nx_illegal = 1'b1;
            end
        endcase
    end

    // Busy bits: writeback clears, accept sets (set wins on the same index), x0 never busy
    assign w_clr_mask = (io_bus.wb_en && (io_bus.wb_addr != 5'd0)) ? (32'd1 << io_bus.wb_addr) : 32'd0;
    assign w_set_mask = (w_accept && w_legal && (w_rd != 5'd0)) ? (32'd1 << w_rd) : 32'd0;
    assign w_busy_nx  = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_nx;
        end
    end

    // ALU-facing register: load on accept, drop valid once consumed, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs1     <= {XLEN{1'b0}};
            r_ex_rs2     <= {XLEN{1'b0}};
            r_ex_funct3  <= 3'd0;
            r_ex_funct7  <= 7'd0;
            r_ex_rd      <= 5'd0;
            r_ex_illegal <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid   <= 1'b1;
            r_ex_rs1     <= w_src1;
            r_ex_rs2     <= w_nx_rs2;
            r_ex_funct3  <= w_funct3;
            r_ex_funct7  <= w_nx_funct7;
            r_ex_rd      <= w_nx_rd;
            r_ex_illegal <= w_nx_illegal;
        end else if (io_bus.ex_ready) begin
            r_ex_valid   <= 1'b0;
        end
    end

    assign io_bus.ex_valid   = r_ex_valid;
    assign io_bus.ex_rs1     = r_ex_rs1;
    assign io_bus.ex_rs2     = r_ex_rs2;
    assign io_bus.ex_funct3  = r_ex_funct3;
    assign io_bus.ex_funct7  = r_ex_funct7;
    assign io_bus.ex_rd      = r_ex_rd;
    assign io_bus.ex_illegal = r_ex_illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized traffic checked against a
// register-array / busy-set reference model of the decode stage.
module tb_id_stage;

    localparam logic [6:0] T_OP   = 7'b0110011;
    localparam logic [6:0] T_IMM  = 7'b0010011;
    localparam logic [6:0] T_LOAD = 7'b0000011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    id_stage_if bus_if ();

    id_stage dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_reg  [32];
    bit          m_busy [32];
    bit          m_v;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rd;
    bit          m_ill;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, T_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, T_IMM};
    endfunction

    // True when the model says register r is forwarded from this cycle's writeback.
    function automatic bit fwd(input logic [4:0] r);
        bit on;
`ifdef ID_BYPASS_EN
        on = 1'b1;
`else
        on = 1'b0;
`endif
        return on && bus_if.wb_en && (bus_if.wb_addr == r) && (r != 5'd0);
    endfunction

    function automatic logic [31:0] srcv(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (fwd(r)) return bus_if.wb_data;
        return m_reg[r];
    endfunction

    task automatic go_idle();
        bus_if.in_valid = 1'b0;
        bus_if.in_instr = 32'd0;
        bus_if.ex_ready = 1'b1;
        bus_if.wb_en    = 1'b0;
        bus_if.wb_addr  = 5'd0;
        bus_if.wb_data  = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        bus_if.wb_en   = 1'b1;
        bus_if.wb_addr = a;
        bus_if.wb_data = d;
        next_cycle();
        bus_if.wb_en   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = ins;
        next_cycle();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        go_idle();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++; if (bus_if.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b expected 0", bus_if.ex_valid); end
        n_assert++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready); end
        n_assert++; if (bus_if.ex_rd !== 5'd0) begin n_fail++; $display("FAIL reset_ex_rd: got %0d expected 0", bus_if.ex_rd); end
        n_assert++; if (bus_if.ex_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_ex_illegal: got %b expected 0", bus_if.ex_illegal); end
        n_assert++; if (bus_if.ex_rs1 !== 32'd0) begin n_fail++; $display("FAIL reset_ex_rs1: got %h expected 0", bus_if.ex_rs1); end
        issue(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6));
        n_assert++; if (bus_if.ex_valid !== 1'b1) begin n_fail++; $display("FAIL reset_x5_valid: got %b expected 1", bus_if.ex_valid); end
        n_assert++; if (bus_if.ex_rs1 !== 32'd0) begin n_fail++; $display("FAIL reset_x5_read: got %h expected 0", bus_if.ex_rs1); end
        do_wb(5'd6, 32'd0);
    endtask

    task automatic test_alu_rr();
        do_wb(5'd1, 32'd20);
        do_wb(5'd2, 32'd30);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        n_assert++; if (bus_if.ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", bus_if.ex_valid); end
        n_assert++; if (bus_if.ex_rs1 !== 32'd20) begin n_fail++; $display("FAIL add_rs1: got %0d expected 20", bus_if.ex_rs1); end
        n_assert++; if (bus_if.ex_rs2 !== 32'd30) begin n_fail++; $display("FAIL add_rs2: got %0d expected 30", bus_if.ex_rs2); end
        n_assert++; if (bus_if.ex_funct7 !== 7'h00) begin n_fail++; $display("FAIL add_funct7: got %h expected 00", bus_if.ex_funct7); end
        n_assert++; if (bus_if.ex_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d expected 3", bus_if.ex_rd); end
        do_wb(5'd3, 32'd0);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3));
        n_assert++; if (bus_if.ex_funct7 !== 7'h20) begin n_fail++; $display("FAIL sub_funct7: got %h expected 20", bus_if.ex_funct7); end
        n_assert++; if (bus_if.ex_rs2 !== 32'd30) begin n_fail++; $display("FAIL sub_rs2: got %0d expected 30", bus_if.ex_rs2); end
        do_wb(5'd3, 32'd0);
    endtask

    task automatic test_imm();
        issue(enc_i(12'hFFF, 5'd1, 3'b000, 5'd4));
        n_assert++; if (bus_if.ex_rs2 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_rs2: got %h expected ffffffff", bus_if.ex_rs2); end
        n_assert++; if (bus_if.ex_funct7 !== 7'h00) begin n_fail++; $display("FAIL addi_funct7: got %h expected 00", bus_if.ex_funct7); end
        n_assert++; if (bus_if.ex_rs1 !== 32'd20) begin n_fail++; $display("FAIL addi_rs1: got %0d expected 20", bus_if.ex_rs1); end
        do_wb(5'd4, 32'd0);
        issue(enc_i({7'h20, 5'd3}, 5'd1, 3'b101, 5'd4));
        n_assert++; if (bus_if.ex_rs2 !== 32'd3) begin n_fail++; $display("FAIL srai_rs2: got %h expected 3", bus_if.ex_rs2); end
        n_assert++; if (bus_if.ex_funct7 !== 7'h20) begin n_fail++; $display("FAIL srai_funct7: got %h expected 20", bus_if.ex_funct7); end
        n_assert++; if (bus_if.ex_funct3 !== 3'b101) begin n_fail++; $display("FAIL srai_funct3: got %b expected 101", bus_if.ex_funct3); end
        do_wb(5'd4, 32'd0);
    endtask

    task automatic test_hazard();
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd5);
        @(negedge clk);
        n_assert++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall1: got %b expected 0", bus_if.in_ready); end
        next_cycle();
        @(negedge clk);
        n_assert++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall2: got %b expected 0", bus_if.in_ready); end
        n_assert++; if (bus_if.ex_valid !== 1'b0) begin n_fail++; $display("FAIL raw_bubble: got %b expected 0", bus_if.ex_valid); end
        next_cycle();
        bus_if.wb_en   = 1'b1;
        bus_if.wb_addr = 5'd3;
        bus_if.wb_data = 32'd50;
        @(negedge clk);
`ifdef ID_BYPASS_EN
        n_assert++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready: got %b expected 1", bus_if.in_ready); end
        next_cycle();
        bus_if.wb_en    = 1'b0;
        bus_if.in_valid = 1'b0;
`else
        n_assert++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL nobyp_wb_cycle: got %b expected 0", bus_if.in_ready); end
        next_cycle();
        bus_if.wb_en = 1'b0;
        @(negedge clk);
        n_assert++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL nobyp_ready: got %b expected 1", bus_if.in_ready); end
        next_cycle();
        bus_if.in_valid = 1'b0;
`endif
        n_assert++; if (bus_if.ex_valid !== 1'b1) begin n_fail++; $display("FAIL raw_valid: got %b expected 1", bus_if.ex_valid); end
        n_assert++; if (bus_if.ex_rs1 !== 32'd50) begin n_fail++; $display("FAIL raw_rs1: got %0d expected 50", bus_if.ex_rs1); end
        n_assert++; if (bus_if.ex_rs2 !== 32'd20) begin n_fail++; $display("FAIL raw_rs2: got %0d expected 20", bus_if.ex_rs2); end
        n_assert++; if (bus_if.ex_rd !== 5'd5) begin n_fail++; $display("FAIL raw_rd: got %0d expected 5", bus_if.ex_rd); end
        do_wb(5'd5, 32'd0);
    endtask

    task automatic test_stall_reset();
        bus_if.ex_ready = 1'b0;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd6));
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = enc_r(7'h00, 5'd1, 5'd2, 3'b000, 5'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_assert++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b expected 0", k, bus_if.in_ready); end
            n_assert++; if (bus_if.ex_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", k, bus_if.ex_valid); end
            n_assert++; if (bus_if.ex_rs1 !== 32'd20 || bus_if.ex_rs2 !== 32'd30 || bus_if.ex_rd !== 5'd6)
                begin n_fail++; $display("FAIL hold_data[%0d]: got %0d/%0d/%0d expected 20/30/6", k, bus_if.ex_rs1, bus_if.ex_rs2, bus_if.ex_rd); end
            next_cycle();
        end
        rst_n = 1'b0;
        #2;
        n_assert++; if (bus_if.ex_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus_if.ex_valid); end
        n_assert++; if (bus_if.ex_rd !== 5'd0) begin n_fail++; $display("FAIL midrst_rd: got %0d expected 0", bus_if.ex_rd); end
        rst_n = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.ex_ready = 1'b1;
        bus_if.in_instr = enc_r(7'h00, 5'd1, 5'd6, 3'b000, 5'd8);
        @(negedge clk);
        n_assert++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_cleared: got %b expected 1", bus_if.in_ready); end
        issue(enc_r(7'h00, 5'd1, 5'd6, 3'b000, 5'd8));
        n_assert++; if (bus_if.ex_rs2 !== 32'd0) begin n_fail++; $display("FAIL midrst_regs_cleared: got %0d expected 0", bus_if.ex_rs2); end
        n_assert++; if (bus_if.ex_rd !== 5'd8) begin n_fail++; $display("FAIL midrst_rd_after: got %0d expected 8", bus_if.ex_rd); end
        do_wb(5'd8, 32'd0);
        do_wb(5'd1, 32'd20);
    endtask

    task automatic test_illegal_x0();
        issue({12'h004, 5'd1, 3'b010, 5'd7, T_LOAD});
        n_assert++; if (bus_if.ex_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b expected 1", bus_if.ex_illegal); end
        n_assert++; if (bus_if.ex_rd !== 5'd0) begin n_fail++; $display("FAIL ill_rd: got %0d expected 0", bus_if.ex_rd); end
        bus_if.in_instr = enc_r(7'h00, 5'd7, 5'd7, 3'b000, 5'd9);
        @(negedge clk);
        n_assert++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_busy: got %b expected 1", bus_if.in_ready); end
        issue(enc_r(7'h00, 5'd7, 5'd7, 3'b000, 5'd9));
        n_assert++; if (bus_if.ex_illegal !== 1'b0) begin n_fail++; $display("FAIL legal_after_ill: got %b expected 0", bus_if.ex_illegal); end
        do_wb(5'd9, 32'd0);
        do_wb(5'd0, 32'd99);
        issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd10));
        n_assert++; if (bus_if.ex_rs1 !== 32'd0 || bus_if.ex_rs2 !== 32'd0)
            begin n_fail++; $display("FAIL x0_read: got %0d/%0d expected 0/0", bus_if.ex_rs1, bus_if.ex_rs2); end
        do_wb(5'd10, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  opc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        bit          is_op, is_imm, legal, haz, exp_rdy, acc, shift;
        logic [31:0] a, b;
        logic [6:0]  f7;
        int          start;
        go_idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
        for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_busy[i] = 1'b0; end
        m_v = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rs1 = 5'($urandom_range(7, 0));
            rs2 = 5'($urandom_range(7, 0));
            rd  = 5'($urandom_range(7, 0));
            case ($urandom_range(7, 0))
                0: begin
                    opc = 7'($urandom);
                    if (opc == T_OP || opc == T_IMM) opc = T_LOAD;
                    ins = {7'($urandom), rs2, rs1, 3'($urandom), rd, opc};
                end
                1, 2, 3: ins = enc_r(7'($urandom), rs2, rs1, 3'($urandom), rd);
                default: ins = enc_i(12'($urandom), rs1, 3'($urandom), rd);
            endcase
            bus_if.in_instr = ins;
            bus_if.in_valid = ($urandom_range(3, 0) != 0);
            bus_if.ex_ready = ($urandom_range(3, 0) != 0);
            bus_if.wb_en    = 1'b0;
            bus_if.wb_data  = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                start = int'($urandom_range(31, 0));
                for (int k = 0; k < 32; k++) begin
                    if (m_busy[(start + k) % 32] && !bus_if.wb_en) begin
                        bus_if.wb_en   = 1'b1;
                        bus_if.wb_addr = 5'((start + k) % 32);
                    end
                end
            end
            if (!bus_if.wb_en && $urandom_range(7, 0) == 0) begin
                bus_if.wb_en   = 1'b1;
                bus_if.wb_addr = 5'($urandom_range(7, 0));
            end
            @(negedge clk);
            opc    = ins[6:0];
            f3     = ins[14:12];
            is_op  = (opc == T_OP);
            is_imm = (opc == T_IMM);
            legal  = is_op || is_imm;
            shift  = (f3 == 3'b001) || (f3 == 3'b101);
            haz    = legal && ((m_busy[rs1] && !fwd(rs1)) || (is_op && m_busy[rs2] && !fwd(rs2)) || m_busy[rd]);
            exp_rdy = (!m_v || bus_if.ex_ready) && !haz;
            n_assert++; if (bus_if.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, bus_if.in_ready, exp_rdy); end
            acc = bus_if.in_valid && exp_rdy;
            a   = srcv(rs1);
            if (is_op)      b = srcv(rs2);
            else if (shift) b = {27'd0, ins[24:20]};
            else            b = {{20{ins[31]}}, ins[31:20]};
            f7  = (is_op || shift) ? ins[31:25] : 7'h00;
            next_cycle();
            if (bus_if.wb_en && bus_if.wb_addr != 5'd0) begin
                m_reg[bus_if.wb_addr]  = bus_if.wb_data;
                m_busy[bus_if.wb_addr] = 1'b0;
            end
            if (acc) begin
                m_v = 1'b1; m_rs1 = a; m_rs2 = b; m_f3 = f3; m_f7 = f7;
                m_ill = !legal;
                m_rd  = legal ? rd : 5'd0;
                if (legal && rd != 5'd0) m_busy[rd] = 1'b1;
            end else if (bus_if.ex_ready) begin
                m_v = 1'b0;
            end
            n_assert++; if (bus_if.ex_valid !== m_v) begin n_fail++; $display("FAIL rnd_ex_valid c%0d: got %b expected %b", c, bus_if.ex_valid, m_v); end
            if (m_v) begin
                n_assert++; if (bus_if.ex_illegal !== m_ill || bus_if.ex_rd !== m_rd)
                    begin n_fail++; $display("FAIL rnd_ill_rd c%0d: got %b/%0d expected %b/%0d", c, bus_if.ex_illegal, bus_if.ex_rd, m_ill, m_rd); end
                if (!m_ill) begin
                    n_assert++; if (bus_if.ex_rs1 !== m_rs1 || bus_if.ex_rs2 !== m_rs2)
                        begin n_fail++; $display("FAIL rnd_operands c%0d: got %h/%h expected %h/%h", c, bus_if.ex_rs1, bus_if.ex_rs2, m_rs1, m_rs2); end
                    n_assert++; if (bus_if.ex_funct3 !== m_f3 || bus_if.ex_funct7 !== m_f7)
                        begin n_fail++; $display("FAIL rnd_funct c%0d: got %b/%h expected %b/%h", c, bus_if.ex_funct3, bus_if.ex_funct7, m_f3, m_f7); end
                end
            end
        end
        go_idle();
    endtask

    initial begin
        go_idle();
        test_reset();
        test_alu_rr();
        test_imm();
        test_hazard();
        test_stall_reset();
        test_illegal_x0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
